mem_alloc_scanner: RTL

- Sequential first-fit allocator for the dynamic memory pool.
- Holds an internal occupancy bitmap of NUM_ROWS rows, each ROW_W bits wide.
- On each allocation request it scans the rows, one per cycle, for the first row where (row & req_mask) == 0. On a hit it sets the requested bits in that row and returns the row address.
- A separate free port clears bits in a given row. The occupancy map is visible to the rest of the allocator.

---
 rtl/mem_alloc_scanner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_alloc_scanner.sv
// Sequential first-fit row allocator over an occupancy bitmap, with a free port.
// Define MEM_ALLOC_NEXT_FIT_EN to start each scan at a rotating next-fit pointer.
module mem_alloc_scanner #(
    parameter int NUM_ROWS = 6,
    parameter int ROW_W    = 6,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ROW_W-1:0]          req_mask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_found,
    output logic [ADDR_W-1:0]         rsp_addr,
    input  logic                      free_valid,
    input  logic [ADDR_W-1:0]         free_addr,
    input  logic [ROW_W-1:0]          free_mask,
    output logic [NUM_ROWS*ROW_W-1:0] occ_flat
);

    localparam int CNT_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t              state, state_next;
    logic [ROW_W-1:0]    occ      [NUM_ROWS];
    logic [ROW_W-1:0]    row_next [NUM_ROWS];
    logic [ROW_W-1:0]    scan_mask;
    logic [ROW_W-1:0]    cur_row;
    logic [ADDR_W-1:0]   scan_idx;
    logic [ADDR_W-1:0]   idx_inc;
    logic [ADDR_W-1:0]   start_idx;
    logic [CNT_W-1:0]    miss_cnt;
    logic                accept;
    logic                hit;
    logic                last_miss;

`ifdef MEM_ALLOC_NEXT_FIT_EN
    logic [ADDR_W-1:0]   fit_ptr;
    assign start_idx = fit_ptr;
`else
    assign start_idx = '0;
`endif

    assign accept  = (state == IDLE) && req_valid;
    assign idx_inc = (scan_idx == ADDR_W'(NUM_ROWS - 1)) ? '0 : scan_idx + 1'b1;

    // Row under test is read from the pre-edge map, so a same-cycle free is not seen.
    always_comb begin
        cur_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (scan_idx == ADDR_W'(r)) cur_row = occ[r];
        end
    end

    assign hit       = (state == SCAN) && ((cur_row & scan_mask) == '0);
    assign last_miss = (state == SCAN) && !hit && (miss_cnt == CNT_W'(NUM_ROWS - 1));

    // Free clears first, then a same-edge hit sets its bits: (old & ~free) | mask.
    // Out-of-range free addresses match no row and are dropped here.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_next[r] = occ[r];
            if (free_valid && (free_addr == ADDR_W'(r))) row_next[r] = row_next[r] & ~free_mask;
            if (hit && (scan_idx == ADDR_W'(r)))         row_next[r] = row_next[r] | scan_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (req_mask == '0) ? RESP : SCAN;
            end
            SCAN: begin
                if (hit || last_miss) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the occupancy rows are reset explicitly because the map must read all-free after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ROWS; r++) occ[r] <= '0;
            scan_mask <= '0;
            scan_idx  <= '0;
            miss_cnt  <= '0;
            rsp_found <= 1'b0;
            rsp_addr  <= '0;
`ifdef MEM_ALLOC_NEXT_FIT_EN
            fit_ptr   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            for (int r = 0; r < NUM_ROWS; r++) occ[r] <= row_next[r];
            if (accept) begin
                scan_mask <= req_mask;
                scan_idx  <= start_idx;
                miss_cnt  <= '0;
                rsp_found <= 1'b0;
                rsp_addr  <= '0;
            end else if (state == SCAN) begin
                if (hit) begin
                    rsp_found <= 1'b1;
                    rsp_addr  <= scan_idx;
`ifdef MEM_ALLOC_NEXT_FIT_EN
                    fit_ptr   <= idx_inc;
`endif
                end else if (last_miss) begin
                    rsp_found <= 1'b0;
                    rsp_addr  <= '0;
                end else begin
                    scan_idx <= idx_inc;
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_flat
        assign occ_flat[g*ROW_W +: ROW_W] = occ[g];
    end

endmodule
